// File: rtl/smux_pkg.sv
// Shared state encodings, select polarity and watchdog helpers for the smux arbiter.
package smux_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_GNT_A = 2'd1;
    localparam state_t ST_GNT_B = 2'd2;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    localparam int              CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    // Counter value on which the watchdog fires; meaningless when the limit is 0.
    function automatic logic [CNT_W-1:0] wd_last(input int unsigned limit);
        return (limit == 0) ? '0 : CNT_W'(limit - 1);
    endfunction

endpackage

// File: rtl/smux_arbiter_if.sv
// Requester, sink and status signals of the smux arbiter.
// master = requesters + sink side, slave = arbiter side.
interface smux_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             ack_a;
    logic             req_b;
    logic [WIDTH-1:0] data_b;
    logic             ack_b;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             timeout;

    modport master (
        output req_a, data_a, req_b, data_b, out_ready,
        input  ack_a, ack_b, sel, out_valid, out_data, timeout
    );

    modport slave (
        input  req_a, data_a, req_b, data_b, out_ready,
        output ack_a, ack_b, sel, out_valid, out_data, timeout
    );
endinterface

// File: rtl/smux_w.sv
// WIDTH-wide 2:1 select, y = sel ? a : b.
// Latency: combinational; backpressure: none.
module smux_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);
    assign y = sel ? a : b;
endmodule

// File: rtl/smux_arbiter.sv
// Round-robin A/B arbiter over a shared 2:1 select with a grant watchdog.
// Latency: request -> out_valid next cycle; backpressure: grant held until out_ready or watchdog.
module smux_arbiter
    import smux_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int WAIT_LIMIT = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    smux_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = wd_last(WAIT_LIMIT);
    localparam logic             WD_EN    = (WAIT_LIMIT != 0);

    state_t           state;
    state_t           state_nxt;
    logic             last_a;
    logic             last_a_nxt;
    logic [CNT_W-1:0] cnt;

    logic             gnt_a;
    logic             gnt_b;
    logic             granted;
    logic             req_own;
    logic             req_other;
    logic             handshake;
    logic             abort;
    logic             wd_fire;

    logic             sel_dat;
    logic             valid_dat;
    logic             ack_a_dat;
    logic             ack_b_dat;
    logic             timeout_dat;
    logic [WIDTH-1:0] mux_dat;

    assign gnt_a     = (state == ST_GNT_A);
    assign gnt_b     = (state == ST_GNT_B);
    assign granted   = gnt_a | gnt_b;
    assign req_own   = gnt_a ? bus.req_a : bus.req_b;
    assign req_other = gnt_a ? bus.req_b : bus.req_a;

    // Priority inside a grant: handshake, then abort, then watchdog.
    assign handshake = granted & bus.out_ready;
    assign abort     = granted & ~bus.out_ready & ~req_own;
    assign wd_fire   = WD_EN & granted & ~bus.out_ready & req_own & (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            last_a <= 1'b0;
        end else begin
            state  <= state_nxt;
            last_a <= last_a_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        last_a_nxt = last_a;
        case (state)
            ST_IDLE: begin
                if (bus.req_a && bus.req_b) begin
                    state_nxt = last_a ? ST_GNT_B : ST_GNT_A;
                end else if (bus.req_a) begin
                    state_nxt = ST_GNT_A;
                end else if (bus.req_b) begin
                    state_nxt = ST_GNT_B;
                end
            end
            ST_GNT_A, ST_GNT_B: begin
                // A finished grant (accepted or timed out) hands straight to a waiting peer.
                if (handshake || wd_fire) begin
                    last_a_nxt = gnt_a;
                    if (req_other) begin
                        state_nxt = gnt_a ? ST_GNT_B : ST_GNT_A;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (abort) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!granted || handshake || abort || wd_fire) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        valid_dat   = granted;
        sel_dat     = gnt_a ? SEL_A : SEL_B;
        ack_a_dat   = gnt_a & bus.out_ready;
        ack_b_dat   = gnt_b & bus.out_ready;
        timeout_dat = wd_fire;
    end

    smux_w #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a   (bus.data_a),
        .b   (bus.data_b),
        .sel (sel_dat),
        .y   (mux_dat)
    );

    assign bus.out_valid = valid_dat;
    assign bus.sel       = sel_dat;
    assign bus.ack_a     = ack_a_dat;
    assign bus.ack_b     = ack_b_dat;
    assign bus.timeout   = timeout_dat;
    assign bus.out_data  = mux_dat;

endmodule
